// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake into the UART transmit FIFO.
interface uart_tx_fifo_if;
    logic [7:0] inData;
    logic       inValid;
    logic       inReady;

    modport master (output inData, output inValid, input inReady);
    modport slave  (input inData, input inValid, output inReady);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first 8N1 serialiser with back-to-back frames.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between DATA and STOP).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_fifo_if.slave                 in_if,
    output logic                          serialOut,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = 12;
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            ser_q, ser_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            push, pop, bit_done;
    logic [2:0]      nxt_bit;

    // Ready is a function of the registered count only, so a full FIFO never
    // accepts a byte even on a cycle that pops.
    assign in_if.inReady = (count_q != (PW+1)'(FIFO_DEPTH));
    assign push          = in_if.inValid && in_if.inReady;
    assign bit_done      = (timer_q == '0);
    assign nxt_bit       = bit_q + 3'd1;

    assign serialOut = ser_q;
    assign busy      = (state_q != IDLE);
    assign fifoCount = count_q;

    always_comb begin
        state_d = state_q;
        timer_d = bit_done ? timer_q : timer_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        ser_d   = ser_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                ser_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = RELOAD;
                    ser_d   = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_done) begin
                timer_d = RELOAD;
                bit_d   = 3'd0;
                ser_d   = shift_q[0];
                state_d = DATA;
            end
            DATA: if (bit_done) begin
                timer_d = RELOAD;
                if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    ser_d   = ^shift_q;
                    state_d = PARITY;
`else
                    ser_d   = 1'b1;
                    state_d = STOP;
`endif
                end else begin
                    bit_d = nxt_bit;
                    ser_d = shift_q[nxt_bit];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) begin
                timer_d = RELOAD;
                ser_d   = 1'b1;
                state_d = STOP;
            end
`endif
            STOP: if (bit_done) begin
                // Chain straight into the next start bit when more bytes wait.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = RELOAD;
                    ser_d   = 1'b0;
                    state_d = START;
                end else begin
                    ser_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                ser_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            ser_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            ser_q    <= ser_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.inData;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: the transmit-side counterpart of the team's 115200-baud, 8N1 receiver, driving the same serial line format from the same 100 MHz clock. Bytes are accepted through a valid/ready handshake into a small FIFO and serialised LSB-first with one start bit and one stop bit, back-to-back with no idle gap. It sits between the processor's memory-mapped I/O write path and the board's TX pin.

## Interface

- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..4095.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of two, 2..16.
- clk  input  1  system clock, 100 MHz; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- inData  input  8  byte to transmit.
- inValid  input  1  inData is valid this cycle.
- inReady  output  1  FIFO can accept a byte; equals (fifoCount != FIFO_DEPTH).
- serialOut  output  1  UART TX line, idle high; registered.
- busy  output  1  high whenever a frame is on the line (state != IDLE).
- fifoCount  output  log2(FIFO_DEPTH)+1  bytes currently queued, excluding the one being shifted.

## Operation

- Push: at a rising edge with inValid && inReady, inData is written at the write pointer and fifoCount increments. inReady depends only on registered fifoCount, so a full FIFO refuses a push even in a cycle where a pop also occurs.
- Pop: a byte is popped only on entry to START. Push and pop in the same cycle leave fifoCount unchanged.
- Pointers wrap modulo FIFO_DEPTH; count is one bit wider than the pointers, so full and empty are unambiguous.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE: serialOut=1. If fifoCount != 0: pop into the shift register, load the timer with CLKS_PER_BIT-1, drive serialOut=0, and go to START.
- START, DATA, PARITY, STOP: the bit timer decrements each cycle. At 0 the timer reloads with CLKS_PER_BIT-1 and the next bit is driven.
- DATA: 8 bits are driven LSB first; a 3-bit counter selects the bit.
- STOP: serialOut=1 for CLKS_PER_BIT cycles. On timer 0: if the FIFO is non-empty, pop and go directly to START (serialOut=0 on the same edge); otherwise go to IDLE.
- inData is never sampled outside the push handshake. A byte in flight is unaffected by later pushes.

## Timing

- Reset values: serialOut=1, busy=0, fifoCount=0, inReady=1, state IDLE, timer 0, FIFO pointers 0.
- Reset asserted mid-frame aborts the frame: serialOut goes high asynchronously and queued bytes are discarded.
- Latency: with the FIFO empty and the state machine in IDLE, a byte accepted at edge k produces a falling edge on serialOut at edge k+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame lasts 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Consecutive queued frames are contiguous: the start bit follows the stop bit with zero extra cycles.
- busy rises on the edge serialOut first goes low. It falls on the edge the state machine returns to IDLE.

## Configuration

- UART_TX_PARITY_EN defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame format is 8E1.
- UART_TX_PARITY_EN undefined: there is no PARITY state. Frame format is 8N1, matching the existing receiver.

## Test plan

- Single byte, CLKS_PER_BIT=4: push 0xA5 at edge k -> serialOut low at edges k+1..k+4; data bits 1,0,1,0,0,1,0,1 for 4 cycles each; high from k+37; busy falls at k+41.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles -> two 40-cycle frames; the second start bit begins the cycle after the first stop bit ends; fifoCount goes 1 -> 1 -> 0.
- Full FIFO, FIFO_DEPTH=4: hold inValid for 6 cycles while frame 1 is sending -> exactly 5 bytes accepted (1 popped plus 4 queued); inReady=0 while fifoCount=4; no byte is lost or duplicated on the line.
- Reset mid-DATA: assert reset during bit 3 of 0x3C with 2 bytes queued -> serialOut=1 immediately; fifoCount=0, busy=0; line stays idle after release.
- Parity (UART_TX_PARITY_EN defined): 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
- Loopback: uart_tx_fifo at CLKS_PER_BIT=868 drives the existing receiver; bytes 0x00, 0x55, 0xAA, 0xFF -> lastByte matches each byte and err stays 0.
